// File: rtl/projection_histogram_pkg.sv
// Shared definitions for the projection histogram: command FSM encoding,
// drain length and the bin saturation ceiling helper.
package projection_histogram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        READ,
        CLEAR
    } state_t;

    // Cycles spent in DRAIN so the two-stage update pipeline empties.
    localparam int DRAIN_CYCLES = 2;

    // All-ones value of a width-bit bin counter (saturation ceiling, COUNT_MAX).
    function automatic logic [31:0] count_max(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/projection_histogram_hist_bin_ram.sv
// hist_bin_ram: one projection axis. Bin memory with a two-stage
// read-modify-write increment pipeline (with forwarding of the previous
// write), a clear write port and a registered read port for streaming.
module hist_bin_ram
    import projection_histogram_pkg::*;
#(
    parameter int DEPTH   = 240,
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               acc_valid,
    input  logic               acc_inc,
    input  logic [ADDR_W-1:0]  acc_addr,
    input  logic               clr_en,
    input  logic [ADDR_W-1:0]  clr_addr,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COUNT_W-1:0] rd_data
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(count_max(COUNT_W));

    logic [COUNT_W-1:0] mem [DEPTH];
    logic [COUNT_W-1:0] rd_q;

    logic               s1_valid;
    logic               s1_inc;
    logic [ADDR_W-1:0]  s1_addr;

    logic               wr_valid;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COUNT_W-1:0] wr_data;

    logic               acc_we;
    logic [ADDR_W-1:0]  raddr;
    logic [COUNT_W-1:0] operand;
    logic [COUNT_W-1:0] sum;

    assign acc_we  = s1_valid & s1_inc;
    assign raddr   = rd_en ? rd_addr : acc_addr;
    assign rd_data = rd_q;

    // Stage 2: pick the freshest bin value and add the increment, saturating.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        operand = rd_q;
        sum     = '0;
        // The memory read for this pixel was issued in the same edge as the
        // previous write landed, so that write must be forwarded.
        if (wr_valid && (wr_addr == s1_addr)) begin
            operand = wr_data;
        end
        if (operand == COUNT_MAX) begin
            sum = COUNT_MAX;
        end else begin
            sum = operand + COUNT_W'(s1_inc);
        end
    end

    // Stage 1 register and last-write record used for forwarding.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_inc   <= 1'b0;
            s1_addr  <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            s1_valid <= acc_valid;
            s1_inc   <= acc_inc;
            s1_addr  <= acc_addr;
            wr_valid <= acc_we;
            wr_addr  <= s1_addr;
            wr_data  <= sum;
        end
    end

    // Bin storage: clear or increment write, plus registered read.
    always_ff @(posedge clk) begin
        // NOTE: the bin array is deliberately not reset so it maps to block RAM; CLEAR zeroes it.
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (acc_we) begin
            mem[s1_addr] <= sum;
        end
        rd_q <= mem[raddr];
    end

endmodule

// File: rtl/projection_histogram.sv
// projection_histogram: per-column and per-row foreground pixel counts with a
// command FSM (IDLE, ACCUM, DRAIN, READ, CLEAR) that accumulates, streams and
// clears both projections. Optional feature macro HIST_PEAK_EN adds running
// peak value/index outputs tracked during READ.
module projection_histogram
    import projection_histogram_pkg::*;
#(
    parameter int IMWIDTH  = 240,
    parameter int IMHEIGHT = 180,
    parameter int ADDR_W   = 8,
    parameter int COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_accum,
    input  logic               stop_accum,
    input  logic               pixel_valid,
    input  logic [ADDR_W-1:0]  x_addr,
    input  logic [ADDR_W-1:0]  y_addr,
    input  logic               pixel_data,
    input  logic               read_req,
    input  logic               clear_req,
    output logic [COUNT_W-1:0] x_hist_out,
    output logic               x_valid,
    output logic               x_last,
    output logic [COUNT_W-1:0] y_hist_out,
    output logic               y_valid,
    output logic               y_last,
    output logic               busy,
    output logic               done
`ifdef HIST_PEAK_EN
    ,
    output logic [COUNT_W-1:0] x_peak_val,
    output logic [COUNT_W-1:0] y_peak_val,
    output logic [ADDR_W-1:0]  x_peak_idx,
    output logic [ADDR_W-1:0]  y_peak_idx
`endif
);

    localparam int N_MAX = (IMWIDTH > IMHEIGHT) ? IMWIDTH : IMHEIGHT;
    // One extra bit so the READ counter can reach N_MAX itself.
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] X_DEPTH   = CNT_W'(IMWIDTH);
    localparam logic [CNT_W-1:0] Y_DEPTH   = CNT_W'(IMHEIGHT);
    localparam logic [CNT_W-1:0] READ_END  = CNT_W'(N_MAX);
    localparam logic [CNT_W-1:0] CLEAR_END = CNT_W'(N_MAX - 1);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(DRAIN_CYCLES - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               done_next;

    logic               x_in_range, y_in_range;
    logic               x_rd_en, y_rd_en;
    logic               x_clr_en, y_clr_en;
    logic [COUNT_W-1:0] x_rd_data, y_rd_data;

    assign x_in_range = ({1'b0, x_addr} < X_DEPTH);
    assign y_in_range = ({1'b0, y_addr} < Y_DEPTH);
    assign x_rd_en    = (state == READ)  && (cnt < X_DEPTH);
    assign y_rd_en    = (state == READ)  && (cnt < Y_DEPTH);
    assign x_clr_en   = (state == CLEAR) && (cnt < X_DEPTH);
    assign y_clr_en   = (state == CLEAR) && (cnt < Y_DEPTH);

    assign busy       = (state != IDLE);
    assign x_hist_out = x_valid ? x_rd_data : '0;
    assign y_hist_out = y_valid ? y_rd_data : '0;

    // Next-state and counter logic for the command FSM.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (clear_req) begin
                    state_next = CLEAR;
                end else if (read_req) begin
                    state_next = READ;
                end else if (start_accum) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (stop_accum) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_END) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            // Runs one cycle past the last address so done follows the last beat.
            READ: begin
                if (cnt == READ_END) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == CLEAR_END) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state, counter and registered stream flags / done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
            y_valid <= 1'b0;
            y_last  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            x_valid <= x_rd_en;
            x_last  <= x_rd_en && (cnt == X_DEPTH - 1'b1);
            y_valid <= y_rd_en;
            y_last  <= y_rd_en && (cnt == Y_DEPTH - 1'b1);
            done    <= done_next;
        end
    end

    hist_bin_ram #(
        .DEPTH   (IMWIDTH),
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W)
    ) u_x_bins (
        .clk       (clk),
        .reset_n   (reset_n),
        .acc_valid ((state == ACCUM) && pixel_valid && x_in_range),
        .acc_inc   (pixel_data),
        .acc_addr  (x_addr),
        .clr_en    (x_clr_en),
        .clr_addr  (cnt[ADDR_W-1:0]),
        .rd_en     (x_rd_en),
        .rd_addr   (cnt[ADDR_W-1:0]),
        .rd_data   (x_rd_data)
    );

    hist_bin_ram #(
        .DEPTH   (IMHEIGHT),
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W)
    ) u_y_bins (
        .clk       (clk),
        .reset_n   (reset_n),
        .acc_valid ((state == ACCUM) && pixel_valid && y_in_range),
        .acc_inc   (pixel_data),
        .acc_addr  (y_addr),
        .clr_en    (y_clr_en),
        .clr_addr  (cnt[ADDR_W-1:0]),
        .rd_en     (y_rd_en),
        .rd_addr   (cnt[ADDR_W-1:0]),
        .rd_data   (y_rd_data)
    );

`ifdef HIST_PEAK_EN
    logic [ADDR_W-1:0] beat_idx;

    // Running peak search over the streamed bins; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_idx   <= '0;
            x_peak_val <= '0;
            y_peak_val <= '0;
            x_peak_idx <= '0;
            y_peak_idx <= '0;
        end else begin
            beat_idx <= cnt[ADDR_W-1:0];
            if ((state == IDLE) && (state_next == READ)) begin
                x_peak_val <= '0;
                y_peak_val <= '0;
                x_peak_idx <= '0;
                y_peak_idx <= '0;
            end else begin
                if (x_valid && (x_hist_out > x_peak_val)) begin
                    x_peak_val <= x_hist_out;
                    x_peak_idx <= beat_idx;
                end
                if (y_valid && (y_hist_out > y_peak_val)) begin
                    y_peak_val <= y_hist_out;
                    y_peak_idx <= beat_idx;
                end
            end
        end
    end
`endif

endmodule
